// File: rtl/control_unit.sv
// control_unit: multicycle Moore FSM driving the 64-bit RISC-V datapath.
// Subset: R add/sub/and/or/xor, addi, lui, loads, stores, beq/bne/blt/bge,
// jal, jalr, ebreak.
// Optional build macro CTRL_TRAP_EN: unsupported opcode or branch funct3
// enters a sticky TRAP state. Without it, unsupported opcodes run as a NOP
// and unsupported branch conditions are never taken.
// Ports:
//   clk, reset (async, active-low), instruction (IR word),
//   alu_zero/alu_equal/alu_greater/alu_less (ALU flags)
//   PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
//   LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite, IMemRead, RegWrite,
//   DMemOp, MemToReg, LoadSplice, StoreSplice, state_out, halted, trap
module control_unit #(
  parameter logic [3:0] ALU_ADD    = 4'd1,
  parameter logic [3:0] ALU_SUB    = 4'd2,
  parameter logic [3:0] ALU_AND    = 4'd3,
  parameter logic [3:0] ALU_OR     = 4'd4,
  parameter logic [3:0] ALU_XOR    = 4'd5,
  parameter logic [3:0] ALU_PASS_B = 4'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        LoadMDR,
  output logic        IRWrite,
  output logic        IMemRead,
  output logic        RegWrite,
  output logic        DMemOp,
  output logic [1:0]  MemToReg,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic [4:0]  state_out,
  output logic        halted,
  output logic        trap
);

`ifdef CTRL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [4:0] S_RST_WAIT = 5'd0;
  localparam logic [4:0] S_FETCH    = 5'd1;
  localparam logic [4:0] S_FETCH_IR = 5'd2;
  localparam logic [4:0] S_DECODE   = 5'd3;
  localparam logic [4:0] S_EXEC_R   = 5'd4;
  localparam logic [4:0] S_EXEC_I   = 5'd5;
  localparam logic [4:0] S_EXEC_LUI = 5'd6;
  localparam logic [4:0] S_WB       = 5'd7;
  localparam logic [4:0] S_ADDR     = 5'd8;
  localparam logic [4:0] S_MEM_RD   = 5'd9;
  localparam logic [4:0] S_MEM_MDR  = 5'd10;
  localparam logic [4:0] S_MEM_WB   = 5'd11;
  localparam logic [4:0] S_MEM_WR   = 5'd12;
  localparam logic [4:0] S_BR_CMP   = 5'd13;
  localparam logic [4:0] S_PC_INC   = 5'd14;
  localparam logic [4:0] S_LINK     = 5'd15;
  localparam logic [4:0] S_JWB      = 5'd16;
  localparam logic [4:0] S_HALT     = 5'd17;
  localparam logic [4:0] S_TRAP     = 5'd18;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic [4:0] r_state;
  logic [4:0] w_next_state;
  logic [4:0] w_dispatch;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_taken;
  logic       w_br_ok;
  logic [1:0] w_splice;
  logic [3:0] w_r_op;
  logic       w_unused_flags;

  assign w_opcode       = instruction[6:0];
  assign w_funct3       = instruction[14:12];
  assign w_unused_flags = alu_zero ^ alu_greater;
  assign state_out      = r_state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST_WAIT;
    else        r_state <= w_next_state;
  end

  // Branch condition and width splice from funct3, R-type ALU function
  always_comb begin
    w_taken = 1'b0;
    w_br_ok = 1'b1;
    case (w_funct3)
      3'b000:  w_taken = alu_equal;
      3'b001:  w_taken = ~alu_equal;
      3'b100:  w_taken = alu_less;
      3'b101:  w_taken = ~alu_less;
      default: w_br_ok = 1'b0;
    endcase
    case (w_funct3)
      3'b011:  w_splice = 2'b00;
      3'b010:  w_splice = 2'b01;
      3'b001:  w_splice = 2'b10;
      3'b000:  w_splice = 2'b11;
      default: w_splice = 2'b00;
    endcase
    case (w_funct3)
      3'b000:  w_r_op = instruction[30] ? ALU_SUB : ALU_ADD;
      3'b100:  w_r_op = ALU_XOR;
      3'b110:  w_r_op = ALU_OR;
      3'b111:  w_r_op = ALU_AND;
      default: w_r_op = ALU_ADD;
    endcase
  end

  // Opcode dispatch out of DECODE
  always_comb begin
    w_dispatch = S_PC_INC;
    case (w_opcode)
      OP_R:      w_dispatch = S_EXEC_R;
      OP_IMM:    w_dispatch = S_EXEC_I;
      OP_LUI:    w_dispatch = S_EXEC_LUI;
      OP_LOAD:   w_dispatch = S_ADDR;
      OP_STORE:  w_dispatch = S_ADDR;
      OP_BRANCH: w_dispatch = (TRAP_EN && !w_br_ok) ? S_TRAP : S_BR_CMP;
      OP_JAL:    w_dispatch = S_LINK;
      OP_JALR:   w_dispatch = S_EXEC_I;
      default: begin
        if (instruction == EBREAK) w_dispatch = S_HALT;
        else if (TRAP_EN)          w_dispatch = S_TRAP;
        else                       w_dispatch = S_PC_INC;
      end
    endcase
  end

  // Next state and Moore outputs
  always_comb begin
    w_next_state = r_state;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCSource     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 4'd0;
    LoadAOut     = 1'b0;
    LoadRegA     = 1'b0;
    LoadRegB     = 1'b0;
    LoadMDR      = 1'b0;
    IRWrite      = 1'b0;
    IMemRead     = 1'b0;
    RegWrite     = 1'b0;
    DMemOp       = 1'b0;
    MemToReg     = 2'b00;
    LoadSplice   = 2'b00;
    StoreSplice  = 2'b00;
    halted       = 1'b0;
    trap         = 1'b0;

    // PC <- PC + 4 tail shared by the final state of most instructions
    if (r_state inside {S_WB, S_MEM_WB, S_MEM_WR, S_PC_INC, S_LINK}) begin
      ALUSrcB  = 2'b01;
      ALUOp    = ALU_ADD;
      PCWrite  = 1'b1;
    end

    case (r_state)
      S_RST_WAIT: w_next_state = S_FETCH;
      S_FETCH: begin
        IMemRead     = 1'b1;
        w_next_state = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        IRWrite      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        LoadRegA     = 1'b1;
        LoadRegB     = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOp        = ALU_ADD;
        LoadAOut     = 1'b1;
        w_next_state = w_dispatch;
      end
      S_EXEC_R: begin
        ALUSrcA      = 1'b1;
        ALUOp        = w_r_op;
        LoadAOut     = 1'b1;
        w_next_state = S_WB;
      end
      S_EXEC_I: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOp        = ALU_ADD;
        LoadAOut     = 1'b1;
        w_next_state = (w_opcode == OP_JALR) ? S_LINK : S_WB;
      end
      S_EXEC_LUI: begin
        ALUSrcB      = 2'b10;
        ALUOp        = ALU_PASS_B;
        LoadAOut     = 1'b1;
        w_next_state = S_WB;
      end
      S_WB: begin
        RegWrite     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOp        = ALU_ADD;
        LoadAOut     = 1'b1;
        w_next_state = (w_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: w_next_state = S_MEM_MDR;
      S_MEM_MDR: begin
        LoadMDR      = 1'b1;
        w_next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite     = 1'b1;
        MemToReg     = 2'b01;
        LoadSplice   = w_splice;
        w_next_state = S_FETCH;
      end
      S_MEM_WR: begin
        DMemOp       = 1'b1;
        StoreSplice  = w_splice;
        w_next_state = S_FETCH;
      end
      S_BR_CMP: begin
        ALUSrcA      = 1'b1;
        ALUOp        = ALU_SUB;
        PCWriteCond  = 1'b1;
        PCSource     = 1'b1;
        w_next_state = w_taken ? S_FETCH : S_PC_INC;
      end
      S_PC_INC: w_next_state = S_FETCH;
      // AOut is not reloaded here so it still holds the jump target for JWB
      S_LINK: w_next_state = S_JWB;
      S_JWB: begin
        RegWrite     = 1'b1;
        MemToReg     = 2'b10;
        PCWrite      = 1'b1;
        PCSource     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_TRAP: trap   = TRAP_EN;
      default: w_next_state = S_RST_WAIT;
    endcase

    PCWriteState = PCWrite | (PCWriteCond & w_taken);
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: reset cases, a table of directed
// instructions with cycle counts, per-cycle checks of random instructions
// against a cycle-list model, and halt / unsupported-opcode sequences.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        alu_zero, alu_equal, alu_greater, alu_less;
  logic        PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUOp;
  logic        LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite, IMemRead;
  logic        RegWrite, DMemOp;
  logic [1:0]  MemToReg, LoadSplice, StoreSplice;
  logic [4:0]  state_out;
  logic        halted, trap;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .alu_equal(alu_equal), .alu_greater(alu_greater), .alu_less(alu_less),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteState(PCWriteState),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .LoadMDR(LoadMDR),
    .IRWrite(IRWrite), .IMemRead(IMemRead), .RegWrite(RegWrite), .DMemOp(DMemOp),
    .MemToReg(MemToReg), .LoadSplice(LoadSplice), .StoreSplice(StoreSplice),
    .state_out(state_out), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, pcws, pcsrc, srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic       ldaout, lda, ldb, ldmdr, irw, imrd, regw, dmem;
    logic [1:0] m2r, lsp, ssp;
    logic       hlt, trp;
  } ctl_t;

  typedef struct {
    logic [31:0] ins;
    logic        eq;
    logic        lt;
    int          cyc;
  } vec_t;

  localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                         A_OR = 4'd4, A_XOR = 4'd5, A_PASSB = 4'd6;

  int   total = 0;
  int   bad   = 0;
  ctl_t exp_q[$];

  function automatic ctl_t sample();
    ctl_t c;
    c = '{pcw:PCWrite, pcwc:PCWriteCond, pcws:PCWriteState, pcsrc:PCSource,
          srca:ALUSrcA, srcb:ALUSrcB, aluop:ALUOp, ldaout:LoadAOut, lda:LoadRegA,
          ldb:LoadRegB, ldmdr:LoadMDR, irw:IRWrite, imrd:IMemRead, regw:RegWrite,
          dmem:DMemOp, m2r:MemToReg, lsp:LoadSplice, ssp:StoreSplice,
          hlt:halted, trp:trap};
    return c;
  endfunction

  task automatic check(input string nm, input int cyc, input ctl_t got, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  // ---------------- reference model: expected control word per cycle ----------------
  function automatic ctl_t pc_plus4(input ctl_t c);
    c.srca = 1'b0; c.srcb = 2'b01; c.aluop = A_ADD; c.pcsrc = 1'b0;
    c.pcw = 1'b1; c.pcws = 1'b1;
    return c;
  endfunction

  function automatic ctl_t alu_step(input logic a_is_reg, input logic [1:0] b_sel, input logic [3:0] op);
    ctl_t c = '0;
    c.srca = a_is_reg; c.srcb = b_sel; c.aluop = op; c.ldaout = 1'b1;
    return c;
  endfunction

  function automatic logic [1:0] width_code(input logic [2:0] f3);
    logic [1:0] tbl [4];
    tbl[0] = 2'b11; tbl[1] = 2'b10; tbl[2] = 2'b01; tbl[3] = 2'b00;
    return tbl[f3[1:0]];
  endfunction

  function automatic logic [3:0] r_func(input logic [2:0] f3, input logic alt);
    if (f3 == 3'd0) return alt ? A_SUB : A_ADD;
    if (f3 == 3'd4) return A_XOR;
    if (f3 == 3'd6) return A_OR;
    if (f3 == 3'd7) return A_AND;
    return A_ADD;
  endfunction

  function automatic bit trap_build();
`ifdef CTRL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic build(input logic [31:0] ins, input logic eq, input logic lt);
    ctl_t c;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit   cond_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
    bit   taken    = (f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq) ||
                     (f3 == 3'd4 && lt) || (f3 == 3'd5 && !lt);
    exp_q.delete();
    c = '0; c.imrd = 1'b1; exp_q.push_back(c);
    c = '0; c.irw = 1'b1; exp_q.push_back(c);
    c = alu_step(1'b0, 2'b10, A_ADD); c.lda = 1'b1; c.ldb = 1'b1; exp_q.push_back(c);
    if (ins == 32'h0010_0073) begin
      c = '0; c.hlt = 1'b1;
      repeat (20) exp_q.push_back(c);
      return;
    end
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111: begin
        if (op == 7'b0110011)      exp_q.push_back(alu_step(1'b1, 2'b00, r_func(f3, ins[30])));
        else if (op == 7'b0010011) exp_q.push_back(alu_step(1'b1, 2'b10, A_ADD));
        else                       exp_q.push_back(alu_step(1'b0, 2'b10, A_PASSB));
        c = pc_plus4('0); c.regw = 1'b1; exp_q.push_back(c);
      end
      7'b0000011: begin
        exp_q.push_back(alu_step(1'b1, 2'b10, A_ADD));
        exp_q.push_back('0);
        c = '0; c.ldmdr = 1'b1; exp_q.push_back(c);
        c = pc_plus4('0); c.regw = 1'b1; c.m2r = 2'b01; c.lsp = width_code(f3); exp_q.push_back(c);
      end
      7'b0100011: begin
        exp_q.push_back(alu_step(1'b1, 2'b10, A_ADD));
        c = pc_plus4('0); c.dmem = 1'b1; c.ssp = width_code(f3); exp_q.push_back(c);
      end
      7'b1100011: begin
        if (trap_build() && !cond_ok) begin
          c = '0; c.trp = 1'b1; repeat (10) exp_q.push_back(c);
        end else begin
          c = '0; c.srca = 1'b1; c.aluop = A_SUB; c.pcwc = 1'b1; c.pcsrc = 1'b1; c.pcws = taken;
          exp_q.push_back(c);
          if (!taken) exp_q.push_back(pc_plus4('0));
        end
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) exp_q.push_back(alu_step(1'b1, 2'b10, A_ADD));
        exp_q.push_back(pc_plus4('0));
        c = '0; c.regw = 1'b1; c.m2r = 2'b10; c.pcw = 1'b1; c.pcws = 1'b1; c.pcsrc = 1'b1;
        exp_q.push_back(c);
      end
      default: begin
        if (trap_build()) begin
          c = '0; c.trp = 1'b1; repeat (10) exp_q.push_back(c);
        end else begin
          exp_q.push_back(pc_plus4('0));
        end
      end
    endcase
  endtask

  // Entry/exit: at a negedge while the DUT is in FETCH
  task automatic drive(input logic [31:0] ins, input logic eq, input logic lt);
    instruction = ins;
    alu_equal   = eq;
    alu_zero    = eq;
    alu_less    = lt;
    alu_greater = !eq && !lt;
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ins, input logic eq, input logic lt);
    drive(ins, eq, lt);
    build(ins, eq, lt);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check(nm, i, sample(), exp_q[i]);
    end
    @(negedge clk);
  endtask

  task automatic measure(input int id, input logic [31:0] ins, input logic eq, input logic lt, input int want);
    int  n = 1;
    bit  found = 1'b0;
    drive(ins, eq, lt);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (IMemRead === 1'b1) found = 1'b1;
      else n++;
    end
    total++;
    if (!found || n != want) begin
      bad++;
      $display("FAIL cycles vec%0d (%h): got=%0d expected=%0d returned=%0d", id, ins, n, want, found);
    end
  endtask

  task automatic fetch_check(input string nm);
    ctl_t c = '0;
    c.imrd = 1'b1;
    check(nm, 0, sample(), c);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1 check({nm, "_async"}, 0, sample(), '0);
    @(negedge clk);
    check({nm, "_held"}, 0, sample(), '0);
    reset = 1'b1;
    @(negedge clk);
    fetch_check({nm, "_release"});
  endtask

  task automatic rand_instr(output logic [31:0] w, output logic eq, output logic lt);
    logic [2:0] f3;
    logic [2:0] r_f3 [4];
    logic [2:0] b_ok [4];
    int cls;
    r_f3[0] = 3'd0; r_f3[1] = 3'd4; r_f3[2] = 3'd6; r_f3[3] = 3'd7;
    b_ok[0] = 3'd0; b_ok[1] = 3'd1; b_ok[2] = 3'd4; b_ok[3] = 3'd5;
    w  = $urandom;
    eq = 1'($urandom_range(0, 1));
    lt = eq ? 1'b0 : 1'($urandom_range(0, 1));
    cls = trap_build() ? $urandom_range(0, 7) : $urandom_range(0, 8);
    case (cls)
      0: begin
        f3 = r_f3[$urandom_range(0, 3)];
        w[6:0] = 7'b0110011; w[14:12] = f3;
        w[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'd0};
      end
      1: begin w[6:0] = 7'b0010011; w[14:12] = 3'd0; end
      2: w[6:0] = 7'b0110111;
      3: begin w[6:0] = 7'b0000011; w[14:12] = 3'($urandom_range(0, 3)); end
      4: begin w[6:0] = 7'b0100011; w[14:12] = 3'($urandom_range(0, 3)); end
      5: begin
        w[6:0] = 7'b1100011;
        w[14:12] = trap_build() ? b_ok[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
      end
      6: w[6:0] = 7'b1101111;
      7: begin w[6:0] = 7'b1100111; w[14:12] = 3'd0; end
      default: begin
        w[6:0] = 7'b0110011;
        while (w[6:0] inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                              7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111})
          w[6:0] = 7'($urandom_range(0, 127));
        if (w == 32'h0010_0073) w[20] = 1'b0;
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [14];
    logic [31:0] w;
    logic        eq, lt;

    tbl[0]  = '{32'h002081B3, 1'b0, 1'b0, 5};  // add
    tbl[1]  = '{32'h402081B3, 1'b0, 1'b0, 5};  // sub
    tbl[2]  = '{32'h00500093, 1'b0, 1'b0, 5};  // addi
    tbl[3]  = '{32'h000012B7, 1'b0, 1'b0, 5};  // lui
    tbl[4]  = '{32'h0080B283, 1'b0, 1'b0, 7};  // ld
    tbl[5]  = '{32'h0080A283, 1'b0, 1'b0, 7};  // lw
    tbl[6]  = '{32'h0020B423, 1'b0, 1'b0, 5};  // sd
    tbl[7]  = '{32'h00208463, 1'b1, 1'b0, 4};  // beq taken
    tbl[8]  = '{32'h00208463, 1'b0, 1'b0, 5};  // beq not taken
    tbl[9]  = '{32'h00209463, 1'b0, 1'b1, 4};  // bne taken
    tbl[10] = '{32'h0020C463, 1'b0, 1'b1, 4};  // blt taken
    tbl[11] = '{32'h0020D463, 1'b0, 1'b1, 5};  // bge not taken
    tbl[12] = '{32'h010000EF, 1'b0, 1'b0, 5};  // jal
    tbl[13] = '{32'h000100E7, 1'b0, 1'b0, 6};  // jalr

    clk = 1'b0;
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_state", 0, sample(), '0);
    reset = 1'b1;
    @(negedge clk);
    fetch_check("first_fetch");

    // Reset in the middle of a load (MEM_RD) aborts it
    drive(32'h0080B283, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("ld_mem_rd", 4, sample(), '0);
    do_reset("ld_abort");

    for (int i = 0; i < 14; i++)
      measure(i, tbl[i].ins, tbl[i].eq, tbl[i].lt, tbl[i].cyc);

    run_instr("add", 32'h002081B3, 1'b0, 1'b0);
    run_instr("ld", 32'h0080B283, 1'b0, 1'b0);
    run_instr("sb", 32'h00208423, 1'b0, 1'b0);
    run_instr("beq_t", 32'h00208463, 1'b1, 1'b0);
    run_instr("beq_nt", 32'h00208463, 1'b0, 1'b1);
    run_instr("jal", 32'h010000EF, 1'b0, 1'b0);
    run_instr("jalr", 32'h000100E7, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rand_instr(w, eq, lt);
      run_instr($sformatf("rand%0d_%h", n, w), w, eq, lt);
    end

    run_instr("ebreak", 32'h0010_0073, 1'b0, 1'b0);
    do_reset("halt_exit");

    run_instr("unsupported", 32'h0000_007F, 1'b0, 1'b0);
    if (trap_build()) do_reset("trap_exit");
    else fetch_check("nop_next_fetch");

    run_instr("beq_f3_010", 32'h0020A463, 1'b1, 1'b0);
    if (trap_build()) do_reset("brtrap_exit");
    else fetch_check("brnop_next_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
